reg_cmd_sequencer: RTL and testbench
====================================

// Module: reg_cmd_sequencer
// PURPOSE
//  Upstream control stage for register_16bit. Accepts register commands over a valid/ready port.
//  For LOAD, assembles a 16-bit word from two 8-bit bytes (memory-side bus).
//  Drives E/FunSel/In of one downstream 16-bit register, with cycle-exact enable pulses.
//  Sits between the byte-wide memory/bus interface and the register datapath.
// PARAMETERS
//  LOW_FIRST  1   1: first byte -> In[7:0], second -> In[15:8]; 0: reversed
//  CNT_W      4   width of cmd_count (INC/DEC repeat count)
//  TIMEOUT    16  idle cycles allowed waiting for a byte before abort; 0 = wait forever
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      synchronous, active-high; priority over all inputs
//  cmd_valid   in   1      command offered
//  cmd_ready   out  1      command accepted when cmd_valid&&cmd_ready
//  cmd_op      in   2      00 DEC, 01 INC, 10 LOAD, 11 CLEAR (same encoding as FunSel)
//  cmd_count   in   CNT_W  INC/DEC: number of E cycles = cmd_count+1; ignored otherwise
//  byte_valid  in   1      byte offered
//  byte_ready  out  1      byte accepted when byte_valid&&byte_ready
//  byte_in     in   8      byte data
//  reg_E       out  1      enable to downstream register
//  reg_FunSel  out  2      function select to downstream register
//  reg_In      out  16     load data to downstream register
//  done        out  1      1-cycle pulse on the last reg_E cycle of a command
//  err         out  1      1-cycle pulse on byte timeout abort
// BEHAVIOUR
//  Reset: state IDLE, reg_E=0, reg_FunSel=00, reg_In=0, done=0, err=0, counters=0.
//  Reset mid-command abandons it; no reg_E pulse in any cycle after reset is sampled.
//  All outputs are driven from registers (no combinational input->output path).
//  States: IDLE, GET_B0, GET_B1, ISSUE, REPEAT.
//  IDLE: cmd_ready=1, byte_ready=0, reg_E=0. On accept:
//    LOAD -> GET_B0; CLEAR -> ISSUE; INC/DEC -> REPEAT, rep_cnt<=cmd_count.
//  GET_B0/GET_B1: byte_ready=1, cmd_ready=0. The byte is stored on handshake.
//    GET_B0 -> GET_B1; GET_B1 -> ISSUE. reg_In updates when the second byte is accepted.
//  ISSUE (1 cycle): reg_E=1, reg_FunSel=op (10 or 11), done=1 -> IDLE.
//  REPEAT: reg_E=1, reg_FunSel=op every cycle. rep_cnt decrements each cycle.
//    When rep_cnt==0: done=1, then -> IDLE.
//  Latency: cmd accepted in cycle N -> first reg_E in cycle N+1.
//    LOAD: second byte accepted in cycle M -> reg_E in cycle M+1.
//  Back-to-back: the cycle after done, state is IDLE and cmd_ready=1. There is no bubble beyond that.
//  cmd_ready=0 outside IDLE; commands offered then are not consumed.
//  byte_ready=0 outside GET_B*; bytes offered then are not consumed.
//  reg_In holds its last loaded value; CLEAR/INC/DEC do not modify it.
//  reg_FunSel holds its last value while reg_E=0.
//  Timeout (TIMEOUT>0): wait_cnt clears on entering GET_B0 and on each byte handshake.
//    It increments each GET_B* cycle without a handshake. When wait_cnt==TIMEOUT-1 with no handshake:
//    err=1 next cycle, state -> IDLE, partial byte discarded, reg_In unchanged, no reg_E.
//  A byte handshake in the same cycle as the timeout boundary wins; no abort.
//  cmd_count max (all ones) gives 2^CNT_W enable cycles. The counter must not wrap early.
// TESTING
//  1 reset, cmd INC count=3 -> reg_E=1,FunSel=01 for 4 consecutive cycles; done on the 4th; cmd_ready back next cycle
//  2 LOAD, bytes 0x34 then 0x12 (LOW_FIRST=1) -> one-cycle reg_E with FunSel=10, reg_In=0x1234, done same cycle
//  3 LOAD, byte 0xAB then byte_valid=0 for TIMEOUT cycles -> err pulse, no reg_E, reg_In unchanged, IDLE
//  4 CLEAR with cmd_count=7, then DEC count=0 back-to-back -> E/11 for 1 cycle, then E/00 for 1 cycle
//  5 reset asserted during REPEAT of DEC count=15 -> reg_E=0 from the next cycle, done never pulses, cmd_ready=1
//  6 byte_valid held high in IDLE, cmd_valid during REPEAT -> neither consumed (byte_ready/cmd_ready low)

Source files
------------

// File: rtl/reg_cmd_sequencer.sv
// rtl/reg_cmd_sequencer.sv - command sequencer driving E/FunSel/In of a 16-bit register
// LOAD gathers two bytes; INC/DEC repeat cmd_count+1 enables; all register-side outputs are flopped.
module reg_cmd_sequencer #(
    parameter int LOW_FIRST = 1,
    parameter int CNT_W     = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic [7:0]       byte_in,
    output logic             reg_E,
    output logic [1:0]       reg_FunSel,
    output logic [15:0]      reg_In,
    output logic             done,
    output logic             err
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {IDLE, GET_B0, GET_B1, ISSUE, REPEAT} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  rep_cnt, rep_cnt_n;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
    logic [7:0]        byte0, byte0_n;
    logic [1:0]        op_q, op_n;
    logic              e_n, done_n, err_n;
    logic [1:0]        fs_n;
    logic [15:0]       in_n;
    logic              timeout_hit;

    assign cmd_ready   = (state == IDLE);
    assign byte_ready  = (state == GET_B0) || (state == GET_B1);
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rep_cnt    <= '0;
            wait_cnt   <= '0;
            byte0      <= '0;
            op_q       <= '0;
            reg_E      <= 1'b0;
            reg_FunSel <= 2'b00;
            reg_In     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            rep_cnt    <= rep_cnt_n;
            wait_cnt   <= wait_cnt_n;
            byte0      <= byte0_n;
            op_q       <= op_n;
            reg_E      <= e_n;
            reg_FunSel <= fs_n;
            reg_In     <= in_n;
            done       <= done_n;
            err        <= err_n;
        end
    end

    // Outputs are computed for the state being entered, so each enable lands one cycle after its trigger.
    always_comb begin
        state_n    = state;
        rep_cnt_n  = rep_cnt;
        wait_cnt_n = wait_cnt;
        byte0_n    = byte0;
        op_n       = op_q;
        e_n        = 1'b0;
        fs_n       = reg_FunSel;
        in_n       = reg_In;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n = cmd_op;
                    if (cmd_op == OP_LOAD) begin
                        state_n    = GET_B0;
                        wait_cnt_n = '0;
                    end else if (cmd_op == OP_CLEAR) begin
                        state_n = ISSUE;
                        e_n     = 1'b1;
                        fs_n    = OP_CLEAR;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = REPEAT;
                        rep_cnt_n = cmd_count;
                        e_n       = 1'b1;
                        fs_n      = cmd_op;
                        done_n    = (cmd_count == '0);
                    end
                end
            end
            GET_B0, GET_B1: begin
                if (byte_valid) begin
                    wait_cnt_n = '0;
                    if (state == GET_B0) begin
                        byte0_n = byte_in;
                        state_n = GET_B1;
                    end else begin
                        in_n    = (LOW_FIRST != 0) ? {byte_in, byte0} : {byte0, byte_in};
                        state_n = ISSUE;
                        e_n     = 1'b1;
                        fs_n    = op_q;
                        done_n  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    wait_cnt_n = '0;
                    state_n    = IDLE;
                    err_n      = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_W'(1);
                end
            end
            ISSUE: state_n = IDLE;
            REPEAT: begin
                // rep_cnt counts enables still owed after the current one; zero means this is the last.
                if (rep_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    rep_cnt_n = rep_cnt - CNT_W'(1);
                    e_n       = 1'b1;
                    done_n    = (rep_cnt == CNT_W'(1));
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// tb/tb_reg_cmd_sequencer.sv - randomized self-checking bench for reg_cmd_sequencer
module tb_reg_cmd_sequencer;
    localparam int LOW_FIRST = 1;
    localparam int CNT_W     = 4;
    localparam int TIMEOUT   = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             byte_valid;
    logic             byte_ready;
    logic [7:0]       byte_in;
    logic             reg_E;
    logic [1:0]       reg_FunSel;
    logic [15:0]      reg_In;
    logic             done;
    logic             err;

    reg_cmd_sequencer #(.LOW_FIRST(LOW_FIRST), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_in(byte_in),
        .reg_E(reg_E), .reg_FunSel(reg_FunSel), .reg_In(reg_In), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference: the register-side view the outside world should see next cycle.
    logic [1:0]  m_fs;
    logic [15:0] m_in;
    logic        x_e, x_done, x_err, x_cr, x_br;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_cyc(input logic e, input logic d, input logic er, input logic cr, input logic br);
        x_e = e; x_done = d; x_err = er; x_cr = cr; x_br = br;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        check("reg_E",      32'(reg_E),      32'(x_e));
        check("reg_FunSel", 32'(reg_FunSel), 32'(m_fs));
        check("reg_In",     32'(reg_In),     32'(m_in));
        check("done",       32'(done),       32'(x_done));
        check("err",        32'(err),        32'(x_err));
        check("cmd_ready",  32'(cmd_ready),  32'(x_cr));
        check("byte_ready", 32'(byte_ready), 32'(x_br));
    endtask

    // Drive junk on the inputs the DUT must not consume in the current state.
    task automatic noise();
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_op     = 2'($urandom);
        cmd_count  = CNT_W'($urandom);
        byte_valid = 1'($urandom_range(0, 1));
        byte_in    = 8'($urandom);
    endtask

    task automatic wait_byte(input int gap, input logic [7:0] d, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            if (i == TIMEOUT - 1) begin
                expect_cyc(0, 0, 1, 1, 0);
                tick();
                aborted = 1'b1;
                return;
            end
            expect_cyc(0, 0, 0, 0, 1);
            tick();
        end
        byte_valid = 1'b1;
        byte_in    = d;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input int g0, input int g1, input int pre);
        bit ab;
        cmd_valid  = 1'b0;
        byte_valid = 1'($urandom_range(0, 1));
        byte_in    = 8'($urandom);
        expect_cyc(0, 0, 0, 1, 0);
        tick();
        repeat (pre) begin
            byte_valid = 1'($urandom_range(0, 1));
            expect_cyc(0, 0, 0, 1, 0);
            tick();
        end
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_count  = cnt;
        byte_valid = 1'($urandom_range(0, 1));
        if (op == 2'b10) begin
            expect_cyc(0, 0, 0, 0, 1);
            tick();
            noise();
            wait_byte(g0, b0, ab);
            if (ab) return;
            expect_cyc(0, 0, 0, 0, 1);
            tick();
            noise();
            wait_byte(g1, b1, ab);
            if (ab) return;
            m_fs = 2'b10;
            m_in = (LOW_FIRST != 0) ? {b1, b0} : {b0, b1};
            expect_cyc(1, 1, 0, 0, 0);
            tick();
            noise();
        end else if (op == 2'b11) begin
            m_fs = 2'b11;
            expect_cyc(1, 1, 0, 0, 0);
            tick();
            noise();
        end else begin
            m_fs = op;
            for (int k = 0; k <= int'(cnt); k++) begin
                expect_cyc(1, (k == int'(cnt)), 0, 0, 0);
                tick();
                noise();
            end
        end
    endtask

    task automatic reset_mid(input logic [1:0] op, input int k);
        cmd_valid = 1'b0;
        expect_cyc(0, 0, 0, 1, 0);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = '1;
        m_fs      = op;
        for (int i = 0; i < k; i++) begin
            expect_cyc(1, 0, 0, 0, 0);
            tick();
            noise();
        end
        reset     = 1'b1;
        cmd_valid = 1'b1;
        m_fs      = 2'b00;
        m_in      = 16'h0000;
        expect_cyc(0, 0, 0, 1, 0);
        tick();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) tick();
    endtask

    function automatic int rand_gap();
        if ($urandom_range(0, 7) == 0) return TIMEOUT - 1 + $urandom_range(0, 2);
        return $urandom_range(0, 3);
    endfunction

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0;
        byte_valid = 1'b0; byte_in = 8'h00;
        m_fs = 2'b00; m_in = 16'h0000;
        expect_cyc(0, 0, 0, 1, 0);
        repeat (2) tick();
        reset = 1'b0;

        run_cmd(2'b01, 4'd3,  8'h00, 8'h00, 0, 0, 0);
        run_cmd(2'b10, 4'd0,  8'h34, 8'h12, 0, 0, 1);
        run_cmd(2'b10, 4'd0,  8'hAB, 8'hCD, 0, TIMEOUT, 0);
        run_cmd(2'b11, 4'd7,  8'h00, 8'h00, 0, 0, 0);
        run_cmd(2'b00, 4'd0,  8'h00, 8'h00, 0, 0, 0);
        run_cmd(2'b10, 4'd0,  8'h5A, 8'hC3, TIMEOUT - 1, TIMEOUT - 1, 0);
        run_cmd(2'b10, 4'd0,  8'h11, 8'h22, TIMEOUT, 0, 0);
        run_cmd(2'b01, 4'd15, 8'h00, 8'h00, 0, 0, 2);
        reset_mid(2'b00, 5);
        run_cmd(2'b10, 4'd0,  8'h78, 8'h56, 1, 2, 0);
        reset_mid(2'b01, 1);

        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom), CNT_W'($urandom), 8'($urandom), 8'($urandom),
                    rand_gap(), rand_gap(), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
